axi_rd_beat_gen: RTL and testbench
==================================

Name: axi_rd_beat_gen

Overview:
- Consumer side of the AXI read-length FIFO.
- Pops one arlen entry per burst from the FIFO and requests exactly arlen+1 data beats from the memory read-data source.
- Drives the AXI slave R channel through a single output register with a correctly placed rlast.
- Sits between the arlen FIFO / memory read path and the AXI slave read-data port.

Parameters:
DATA_W, 64, width of read data beat.

Ports:
clk  input  1  system clock, 400 MHz.
rst  input  1  asynchronous reset, active-high.
arlen_fifo_empty  input  1  arlen FIFO empty flag.
arlen_fifo_dout  input  8  arlen FIFO head entry; valid whenever not empty.
arlen_fifo_rd  output  1  pop request to arlen FIFO, one-cycle pulse.
rd_data_valid  input  1  memory read-data beat available.
rd_data  input  DATA_W  memory read-data beat.
rd_data_ready  output  1  beat accepted from memory this cycle when high with rd_data_valid.
axi_s_rvalid  output  1  AXI R valid.
axi_s_rdata  output  DATA_W  AXI R data.
axi_s_rlast  output  1  AXI R last beat of burst.
axi_s_rready  input  1  AXI R ready from master.
busy  output  1  high while in BURST state.
burst_done  output  1  one-cycle pulse when the last beat handshakes on R.

Behaviour:
- Reset: asynchronous and active-high. Immediately forces state IDLE, len_q=0, beat_cnt=0, axi_s_rvalid=0, axi_s_rlast=0, axi_s_rdata=0, burst_done=0. Combinational outputs arlen_fifo_rd, rd_data_ready and busy read 0 while in reset.
- States: IDLE, BURST.
- IDLE:
  - arlen_fifo_rd = !arlen_fifo_empty (combinational).
  - On a pop cycle: latch len_q <= arlen_fifo_dout, clear beat_cnt <= 0, go to BURST.
  - The pop is a single-cycle pulse because the state leaves IDLE on that edge.
- BURST:
  - out_free = !axi_s_rvalid || axi_s_rready.
  - rd_data_ready = out_free (combinational; 0 in IDLE).
  - Beat load: rd_data_valid && rd_data_ready → axi_s_rdata <= rd_data, axi_s_rvalid <= 1, axi_s_rlast <= (beat_cnt == len_q), beat_cnt <= beat_cnt + 1.
  - If the loaded beat is the last one (beat_cnt == len_q): state <= IDLE. The last beat may still be waiting in the output register while IDLE pops the next entry.
- Output register:
  - If axi_s_rvalid && axi_s_rready and no new load this cycle: axi_s_rvalid <= 0, axi_s_rlast <= 0.
  - rdata, rvalid and rlast are held stable while rvalid=1 and rready=0 (AXI rule).
- burst_done is registered: set for one cycle after the edge where a beat with axi_s_rlast=1 handshakes.
- Widths:
  - beat_cnt is 9 bits so that arlen=255 (256 beats) compares without wrap.
  - Compare against zero-extended len_q.
- Latency:
  - FIFO becomes non-empty in IDLE at cycle N → pop at N, BURST at N+1.
  - With rd_data_valid=1 at N+1, axi_s_rvalid=1 at N+2.
  - Sustained throughput with rready=1: 1 beat/cycle.
  - Inter-burst bubble: exactly 1 idle cycle on the rd_data side (the IDLE pop cycle).
- Boundaries:
  - arlen=0: single beat with rlast=1.
  - FIFO empty in IDLE: no pop, no rd_data_ready.
  - Extra rd_data_valid while in IDLE: ignored, not accepted.
  - Simultaneous drain and load in the same cycle: load wins; rvalid stays 1.
  - Reset mid-burst: all state cleared; the burst is abandoned and the FIFO is not re-popped.

Test Plan:
- Reset held 3 cycles, FIFO empty → arlen_fifo_rd=0, axi_s_rvalid=0, rd_data_ready=0, busy=0 throughout.
- FIFO head arlen=0, rd_data=0xA5 valid, rready=1 → one pop pulse; one R beat with rdata=0xA5, rlast=1; burst_done pulses once.
- Entries arlen=1 then arlen=4, rd_data_valid always 1, rready=1:
  - exactly 2 beats (rlast on beat 2), then 5 beats (rlast on beat 5);
  - two pop pulses;
  - one idle rd_data_ready cycle between the bursts.
- arlen=3 with rready toggling 1,0,0,1,...:
  - rdata/rlast stable during stalls;
  - rd_data_ready low while rvalid=1 and rready=0;
  - 4 beats delivered in order, rlast only on beat 4.
- arlen=255, continuous data → 256 beats with rlast only on beat 256; no early rlast from counter wrap.
- rst asserted after beat 2 of an arlen=7 burst → rvalid/rlast drop immediately, state IDLE; the next FIFO entry starts a fresh burst with beat_cnt=0.

Source files
------------

// File: rtl/axi_rd_beat_gen.sv
// Consumer of the AXI read-length FIFO: pops one arlen per burst and streams exactly
// arlen+1 memory beats onto the AXI R channel through a single output register.
module axi_rd_beat_gen #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arlen_fifo_empty,
  input  logic [7:0]        arlen_fifo_dout,
  output logic              arlen_fifo_rd,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_data_ready,
  output logic              axi_s_rvalid,
  output logic [DATA_W-1:0] axi_s_rdata,
  output logic              axi_s_rlast,
  input  logic              axi_s_rready,
  output logic              busy,
  output logic              burst_done
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q;
  logic [8:0] beat_cnt_q;  // 9 bits so arlen=255 reaches 255 without wrapping
  logic       out_free;
  logic       load;
  logic       last_beat;
  logic       r_hs;

  assign out_free  = !axi_s_rvalid || axi_s_rready;
  assign load      = rd_data_valid && rd_data_ready;
  assign last_beat = (beat_cnt_q == {1'b0, len_q});
  assign r_hs      = axi_s_rvalid && axi_s_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (arlen_fifo_rd) state_d = StBurst;
      StBurst: if (load && last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gated by rst so no pop or accept can leak out while reset is held.
  always_comb begin
    arlen_fifo_rd = 1'b0;
    rd_data_ready = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle:  arlen_fifo_rd = !arlen_fifo_empty;
        StBurst: begin
          busy          = 1'b1;
          rd_data_ready = out_free;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= 8'd0;
      beat_cnt_q   <= 9'd0;
      axi_s_rvalid <= 1'b0;
      axi_s_rlast  <= 1'b0;
      axi_s_rdata  <= '0;
      burst_done   <= 1'b0;
    end else begin
      burst_done <= r_hs && axi_s_rlast;
      if (arlen_fifo_rd) begin
        len_q      <= arlen_fifo_dout;
        beat_cnt_q <= 9'd0;
      end
      // A load in the same cycle as a drain wins, keeping rvalid high.
      if (load) begin
        axi_s_rdata  <= rd_data;
        axi_s_rvalid <= 1'b1;
        axi_s_rlast  <= last_beat;
        beat_cnt_q   <= beat_cnt_q + 9'd1;
      end else if (r_hs) begin
        axi_s_rvalid <= 1'b0;
        axi_s_rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_beat_gen.sv
// Bench for axi_rd_beat_gen: cycle-exact vector table, then burst-level scoreboard runs
// (stall pattern, 256-beat burst, reset mid-burst, randomized traffic).
module tb_axi_rd_beat_gen;

  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arlen_fifo_empty = 1'b1;
  logic [7:0]        arlen_fifo_dout = 8'd0;
  logic              arlen_fifo_rd;
  logic              rd_data_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_data_ready;
  logic              axi_s_rvalid;
  logic [DATA_W-1:0] axi_s_rdata;
  logic              axi_s_rlast;
  logic              axi_s_rready = 1'b0;
  logic              busy;
  logic              burst_done;

  always #5 clk = ~clk;

  axi_rd_beat_gen #(.DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .arlen_fifo_empty (arlen_fifo_empty),
    .arlen_fifo_dout  (arlen_fifo_dout),
    .arlen_fifo_rd    (arlen_fifo_rd),
    .rd_data_valid    (rd_data_valid),
    .rd_data          (rd_data),
    .rd_data_ready    (rd_data_ready),
    .axi_s_rvalid     (axi_s_rvalid),
    .axi_s_rdata      (axi_s_rdata),
    .axi_s_rlast      (axi_s_rlast),
    .axi_s_rready     (axi_s_rready),
    .busy             (busy),
    .burst_done       (burst_done)
  );

  typedef struct {
    logic        rst;
    logic        empty;
    logic [7:0]  dout;
    logic        rdv;
    logic [63:0] rdata;
    logic        rready;
    logic        e_pop;
    logic        e_rdr;
    logic        e_busy;
    logic        e_rv;
    logic        e_rl;
    logic [63:0] e_rdata;
    logic        e_done;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  vec_t        tbl[19];
  logic [7:0]  fifo_q[$];
  logic [63:0] src_q[$];
  beat_t       exp_q[$];
  int          remaining = 0;  // beats still owed to the burst in progress
  logic        done_exp = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(int r, int e, int d, int v, int rd, int rr,
                              int p, int rdy, int b, int rv, int rl, int erd, int dn);
    vec_t t;
    t.rst = 1'(r);  t.empty = 1'(e);  t.dout = 8'(d);   t.rdv = 1'(v);
    t.rdata = 64'(rd);  t.rready = 1'(rr);
    t.e_pop = 1'(p);  t.e_rdr = 1'(rdy);  t.e_busy = 1'(b);  t.e_rv = 1'(rv);
    t.e_rl = 1'(rl);  t.e_rdata = 64'(erd);  t.e_done = 1'(dn);
    return t;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // mode 0: rready pattern 1,0,0; mode 1: rready=1, data always offered; mode 2: random.
  task automatic run_stream(input int mode, input int max_cycles, input int stop_hs);
    int    cyc = 0;
    int    hs = 0;
    logic  pop_s, acc_s, hs_s, exp_pop, exp_rdr;
    beat_t b;
    while ((fifo_q.size() != 0 || src_q.size() != 0 || exp_q.size() != 0 ||
            remaining != 0 || done_exp) && cyc < max_cycles &&
           !(stop_hs != 0 && hs >= stop_hs)) begin
      arlen_fifo_empty = (fifo_q.size() == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
      arlen_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
      rd_data_valid    = (src_q.size() != 0) && (mode != 2 || $urandom_range(0, 4) != 0);
      rd_data          = (src_q.size() != 0) ? src_q[0] : {$urandom, $urandom};
      case (mode)
        0:       axi_s_rready = (cyc % 3 == 0);
        1:       axi_s_rready = 1'b1;
        default: axi_s_rready = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      exp_pop = (remaining == 0) && !arlen_fifo_empty;
      exp_rdr = (remaining != 0) && (!axi_s_rvalid || axi_s_rready);
      chk1("pop", arlen_fifo_rd, exp_pop);
      chk1("rd_ready", rd_data_ready, exp_rdr);
      chk1("busy", busy, remaining != 0);
      chk1("rvalid", axi_s_rvalid, exp_q.size() != 0);
      chk1("burst_done", burst_done, done_exp);
      if (exp_q.size() != 0) begin
        chk64("rdata", axi_s_rdata, exp_q[0].data);
        chk1("rlast", axi_s_rlast, exp_q[0].last);
      end
      pop_s = arlen_fifo_rd && !arlen_fifo_empty;
      acc_s = rd_data_ready && rd_data_valid;
      hs_s  = axi_s_rvalid && axi_s_rready;
      @(posedge clk);
      #1;
      done_exp = 1'b0;
      if (hs_s) begin
        hs++;
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          done_exp = b.last;
        end
      end
      if (pop_s && remaining == 0 && fifo_q.size() != 0) begin
        remaining = int'(fifo_q.pop_front()) + 1;
      end
      if (acc_s && remaining > 0 && src_q.size() != 0) begin
        b.data = src_q.pop_front();
        b.last = (remaining == 1);
        exp_q.push_back(b);
        remaining--;
      end
      cyc++;
    end
    chk1("stream_in_budget", cyc < max_cycles, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_rvalid"}, axi_s_rvalid, 1'b0);
    chk1({tag, "_rlast"}, axi_s_rlast, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_pop"}, arlen_fifo_rd, 1'b0);
    chk1({tag, "_rd_ready"}, rd_data_ready, 1'b0);
    chk1({tag, "_done"}, burst_done, 1'b0);
  endtask

  initial begin
    // {rst,empty,dout,rdv,rdata,rready | pop,rdr,busy,rv,rl,rdata,done}
    tbl[0]  = mk(1, 1, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0);
    tbl[1]  = mk(1, 1, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0);
    tbl[2]  = mk(1, 0, 0, 1, 'hA5, 1,  0, 0, 0, 0, 0, 'h00, 0);
    tbl[3]  = mk(0, 0, 0, 1, 'hA5, 1,  1, 0, 0, 0, 0, 'h00, 0);
    tbl[4]  = mk(0, 1, 0, 1, 'hA5, 1,  0, 1, 1, 0, 0, 'h00, 0);
    tbl[5]  = mk(0, 1, 0, 1, 'h5A, 1,  0, 0, 0, 1, 1, 'hA5, 0);
    tbl[6]  = mk(0, 1, 0, 0, 'h00, 1,  0, 0, 0, 0, 0, 'hA5, 1);
    tbl[7]  = mk(0, 1, 0, 0, 'h00, 1,  0, 0, 0, 0, 0, 'hA5, 0);
    tbl[8]  = mk(0, 0, 1, 1, 'h11, 1,  1, 0, 0, 0, 0, 'hA5, 0);
    tbl[9]  = mk(0, 0, 4, 1, 'h11, 1,  0, 1, 1, 0, 0, 'hA5, 0);
    tbl[10] = mk(0, 0, 4, 1, 'h12, 1,  0, 1, 1, 1, 0, 'h11, 0);
    tbl[11] = mk(0, 0, 4, 1, 'h13, 1,  1, 0, 0, 1, 1, 'h12, 0);
    tbl[12] = mk(0, 1, 0, 1, 'h13, 1,  0, 1, 1, 0, 0, 'h12, 1);
    tbl[13] = mk(0, 1, 0, 1, 'h14, 1,  0, 1, 1, 1, 0, 'h13, 0);
    tbl[14] = mk(0, 1, 0, 1, 'h15, 1,  0, 1, 1, 1, 0, 'h14, 0);
    tbl[15] = mk(0, 1, 0, 1, 'h16, 1,  0, 1, 1, 1, 0, 'h15, 0);
    tbl[16] = mk(0, 1, 0, 1, 'h17, 1,  0, 1, 1, 1, 0, 'h16, 0);
    tbl[17] = mk(0, 1, 0, 1, 'h18, 1,  0, 0, 0, 1, 1, 'h17, 0);
    tbl[18] = mk(0, 1, 0, 0, 'h00, 1,  0, 0, 0, 0, 0, 'h17, 1);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;  arlen_fifo_empty = tbl[i].empty;  arlen_fifo_dout = tbl[i].dout;
      rd_data_valid = tbl[i].rdv;  rd_data = tbl[i].rdata;  axi_s_rready = tbl[i].rready;
      @(negedge clk);
      chk1($sformatf("v%0d_pop", i), arlen_fifo_rd, tbl[i].e_pop);
      chk1($sformatf("v%0d_rd_ready", i), rd_data_ready, tbl[i].e_rdr);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk1($sformatf("v%0d_rvalid", i), axi_s_rvalid, tbl[i].e_rv);
      chk1($sformatf("v%0d_rlast", i), axi_s_rlast, tbl[i].e_rl);
      chk64($sformatf("v%0d_rdata", i), axi_s_rdata, tbl[i].e_rdata);
      chk1($sformatf("v%0d_done", i), burst_done, tbl[i].e_done);
      @(posedge clk);
      #1;
    end

    // arlen=3 under rready stalls
    fifo_q.push_back(8'd3);
    for (int i = 0; i < 4; i++) src_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
    run_stream(0, 100, 0);

    // arlen=255: rlast must land on beat 256 only
    fifo_q.push_back(8'd255);
    for (int i = 0; i < 256; i++) src_q.push_back(64'hBEEF_0000_0000_0000 + 64'(i));
    run_stream(1, 400, 0);

    // reset after beat 2 of an arlen=7 burst
    fifo_q.push_back(8'd7);
    fifo_q.push_back(8'd2);
    for (int i = 0; i < 8; i++) src_q.push_back(64'h7000 + 64'(i));
    run_stream(1, 100, 2);
    arlen_fifo_empty = 1'b0;
    arlen_fifo_dout  = 8'd2;
    rd_data_valid    = 1'b1;
    axi_s_rready     = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    src_q.delete();
    exp_q.delete();
    remaining = 0;
    done_exp  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) src_q.push_back(64'h2000 + 64'(i));
    run_stream(1, 50, 0);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 7);
      fifo_q.push_back(8'(len));
      for (int j = 0; j <= len; j++) src_q.push_back({$urandom, $urandom});
    end
    run_stream(2, 6000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
